// File: rtl/fp_latency_buffer_if.sv
// Handshake, core-side and result bundle of fp_latency_buffer.
// The buffer takes the slave view; the caller/core side takes the master view.
interface fp_latency_buffer_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int RESULT_WIDTH = 32,
    parameter int TAG_WIDTH    = 4,
    parameter int FIFO_DEPTH   = 8
);
    localparam int OCC_WIDTH = $clog2(FIFO_DEPTH + 1);

    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_WIDTH-1:0]   in_data;
    logic [TAG_WIDTH-1:0]    in_tag;
    logic [DATA_WIDTH-1:0]   core_data;
    logic [RESULT_WIDTH-1:0] core_result;
    logic                    out_valid;
    logic                    out_ready;
    logic [RESULT_WIDTH-1:0] out_data;
    logic [TAG_WIDTH-1:0]    out_tag;
    logic [OCC_WIDTH-1:0]    occupancy;

    modport slave (
        input  in_valid, in_data, in_tag, core_result, out_ready,
        output in_ready, core_data, out_valid, out_data, out_tag, occupancy
    );

    modport master (
        output in_valid, in_data, in_tag, core_result, out_ready,
        input  in_ready, core_data, out_valid, out_data, out_tag, occupancy
    );
endinterface

// File: rtl/fp_latency_buffer.sv
// Go/done wrapper around a fixed-latency non-stallable FP core with a credit-guarded result FIFO.
// Optional statistics counters are enabled by defining FP_LATENCY_BUFFER_STATS_EN.
module fp_latency_buffer #(
    parameter int DATA_WIDTH   = 32,
    parameter int RESULT_WIDTH = 32,
    parameter int LATENCY      = 6,
    parameter int TAG_WIDTH    = 4,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    fp_latency_buffer_if.slave  bus
`ifdef FP_LATENCY_BUFFER_STATS_EN
    ,
    output logic [31:0]         stat_ops,
    output logic [31:0]         stat_stall,
    output logic [31:0]         stat_backpressure
`endif
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PW    = AW + 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(FIFO_DEPTH);

    logic                    accept;
    logic                    push;
    logic                    pop;
    logic                    fifoEmpty;
    logic                    fifoFull;
    logic [LATENCY-1:0]      validPipe_q;
    logic [TAG_WIDTH-1:0]    tagPipe_q [LATENCY];
    logic [PW-1:0]           wrPtr_q;
    logic [PW-1:0]           rdPtr_q;
    logic [OCC_W-1:0]        occ_q;
    logic [OCC_W-1:0]        occ_d;
    logic [RESULT_WIDTH-1:0] dataMem_q [FIFO_DEPTH];
    logic [TAG_WIDTH-1:0]    tagMem_q  [FIFO_DEPTH];

    // Credits cover both in-flight ops and buffered results, so the FIFO can never overflow.
    assign bus.in_ready  = occ_q < DEPTH_OCC;
    assign accept        = bus.in_valid & bus.in_ready;
    assign bus.core_data = bus.in_data;

    assign fifoEmpty     = wrPtr_q == rdPtr_q;
    assign fifoFull      = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign pop           = bus.out_valid & bus.out_ready;
    assign push          = validPipe_q[LATENCY-1] & (~fifoFull | pop);

    assign bus.out_valid = ~fifoEmpty;
    assign bus.out_data  = dataMem_q[rdPtr_q[AW-1:0]];
    assign bus.out_tag   = tagMem_q[rdPtr_q[AW-1:0]];
    assign bus.occupancy = occ_q;

    always_comb begin
        occ_d = occ_q;
        case ({accept, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            validPipe_q <= '0;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            occ_q       <= '0;
        end else begin
            validPipe_q[0] <= accept;
            for (int i = 1; i < LATENCY; i++) begin
                validPipe_q[i] <= validPipe_q[i-1];
            end
            if (push) begin
                wrPtr_q <= wrPtr_q + PW'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + PW'(1);
            end
            occ_q <= occ_d;
        end
    end

    // Tags and stored results only matter where a valid bit or pointer says so.
    always_ff @(posedge clock) begin
        tagPipe_q[0] <= bus.in_tag;
        for (int i = 1; i < LATENCY; i++) begin
            tagPipe_q[i] <= tagPipe_q[i-1];
        end
        if (push) begin
            dataMem_q[wrPtr_q[AW-1:0]] <= bus.core_result;
            tagMem_q[wrPtr_q[AW-1:0]]  <= tagPipe_q[LATENCY-1];
        end
    end

`ifdef FP_LATENCY_BUFFER_STATS_EN
    logic [31:0] statOps_q;
    logic [31:0] statStall_q;
    logic [31:0] statBp_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            statOps_q   <= '0;
            statStall_q <= '0;
            statBp_q    <= '0;
        end else begin
            if (accept && statOps_q != '1) begin
                statOps_q <= statOps_q + 32'd1;
            end
            if (bus.in_valid && !bus.in_ready && statStall_q != '1) begin
                statStall_q <= statStall_q + 32'd1;
            end
            if (bus.out_valid && !bus.out_ready && statBp_q != '1) begin
                statBp_q <= statBp_q + 32'd1;
            end
        end
    end

    assign stat_ops          = statOps_q;
    assign stat_stall        = statStall_q;
    assign stat_backpressure = statBp_q;
`endif
endmodule

// File: doc/fp_latency_buffer.md
Name: fp_latency_buffer

Overview:
Parametrised go/done wrapper for a fixed-latency, non-stallable pipelined FP core, such as int-to-float, add or multiply. Tracks in-flight operations with a valid/tag shift pipeline and captures results into an output FIFO. Uses credit-based flow control, so consumers may apply backpressure without ever losing a core result. Sits between the Blarney-generated datapath and the vendor FP IP.

Parameters:
DATA_WIDTH, 32, operand width driven to the core
RESULT_WIDTH, 32, core result width
LATENCY, 6, core latency in cycles; legal range 1..64
TAG_WIDTH, 4, caller tag carried alongside each operation
FIFO_DEPTH, 8, result FIFO entries; power of two, must be >= LATENCY+1

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  operation request
in_ready  out  1  block can accept an operation this cycle
in_data  in  DATA_WIDTH  operand
in_tag  in  TAG_WIDTH  request tag
core_data  out  DATA_WIDTH  operand to core; combinational copy of in_data
core_result  in  RESULT_WIDTH  core output, LATENCY cycles after the operand
out_valid  out  1  FIFO head holds a result
out_ready  in  1  consumer takes the head this cycle
out_data  out  RESULT_WIDTH  head result
out_tag  out  TAG_WIDTH  head tag
occupancy  out  clog2(FIFO_DEPTH+1)  in-flight ops plus FIFO entries

Behaviour:
- Clock and reset: single clock `clock`. Reset `reset_n` is asynchronous and active-low.
- Reset values: valid pipeline = 0; FIFO pointers = 0; occupancy = 0; out_valid = 0; in_ready = 1. out_data and out_tag are don't-care while out_valid = 0.
- Accept: accept = in_valid & in_ready.
- in_ready: in_ready = (occupancy < FIFO_DEPTH). It is a pure function of registered state and does not depend combinationally on out_ready.
- Valid/tag pipeline: LATENCY stages, stage 0 loaded with {accept, in_tag}. The core needs no enable; bubbles are tracked only by the valid bits.
- FIFO write: when the last stage is valid, write {core_result, tag} into the FIFO at the edge ending cycle t+LATENCY (t = accept cycle). out_valid rises in cycle t+LATENCY+1, so minimum accept-to-out_valid latency is LATENCY+1.
- Throughput: one op per cycle sustained when out_ready = 1.
- Output FIFO: first-word-fallthrough, registered storage, in-order. Pop = out_valid & out_ready. Push and pop in the same cycle are both legal, including when the FIFO is full or empty-with-push; the pushed entry becomes the head next cycle.
- Occupancy update: occupancy(next) = occupancy + accept - pop.
- Overflow guarantee: the credit rule makes FIFO overflow impossible. The bench asserts push never occurs while FIFO count = FIFO_DEPTH with no pop.
- Full boundary: at occupancy = FIFO_DEPTH, in_ready = 0. A pop in that cycle raises in_ready the next cycle, not combinationally.
- Out-of-range inputs: out_ready while out_valid = 0 is ignored. in_valid while in_ready = 0 is ignored, and the caller must hold the request.
- Reset mid-operation: all in-flight and buffered results are discarded. Stale core_result values emerging after reset are never written, because the valid bits are cleared.
- Pointer widths: log2(FIFO_DEPTH)+1 bits with a wrap bit; full/empty derived from pointer compare.

Optional Feature:
- Macro: FP_LATENCY_BUFFER_STATS_EN.
- When defined, adds three outputs, all cleared by reset_n:
  - stat_ops (32 bits): counts accepts.
  - stat_stall (32 bits): counts cycles with in_valid & !in_ready.
  - stat_backpressure (32 bits): counts cycles with out_valid & !out_ready.
- Counters saturate at all-ones.
- When undefined, these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Single op, defaults: in_data 0x0000_0005, tag 3 accepted at cycle 10; model core returns 0x40A0_0000 at cycle 16 -> out_valid first high at cycle 17 with out_data 0x40A0_0000, out_tag 3; occupancy back to 0 after pop.
- Streaming: 20 back-to-back ops, tags 0..15 wrapping, out_ready = 1 -> in_ready never drops; results emerge in order one per cycle starting 7 cycles after the first accept.
- Backpressure: out_ready = 0, in_valid held -> exactly 8 accepts, then in_ready = 0 and occupancy = 8. Raise out_ready -> 8 results in order, and in_ready rises 1 cycle after the first pop.
- Full with simultaneous events: at occupancy = 8, a pop plus a held in_valid -> accept occurs the cycle after the pop, occupancy stays 8, no overflow assertion fires.
- Reset mid-flight: 3 ops in pipeline and 2 in FIFO, pulse reset_n low for 1 cycle (asynchronously, mid-cycle) -> outputs at reset values immediately; no out_valid for 10 cycles despite core_result activity.
- Stats build: 5 accepts, 4 stall cycles, 2 backpressure cycles -> stat_ops = 5, stat_stall = 4, stat_backpressure = 2.
